// File: rtl/prng_arbiter_if.sv
// prng_arbiter_if: requester and PRNG handshake bundle for prng_arbiter
interface prng_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int OUTPUT_SIZE = 4
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*OUTPUT_SIZE-1:0] req_exclude;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [OUTPUT_SIZE-1:0]         rsp_data;
  logic                           rsp_error;
  logic                           busy;
  logic                           prng_next;
  logic [OUTPUT_SIZE-1:0]         prng_exclude;
  logic                           prng_valid;
  logic [OUTPUT_SIZE-1:0]         prng_data;
  modport slave (
    input  req, req_exclude, prng_valid, prng_data,
    output rsp_valid, rsp_data, rsp_error, busy, prng_next, prng_exclude
  );
  modport master (
    output req, req_exclude, prng_valid, prng_data,
    input  rsp_valid, rsp_data, rsp_error, busy, prng_next, prng_exclude
  );
endinterface

// File: rtl/prng_arbiter.sv
// prng_arbiter: round-robin sharing of one PRNG among NUM_REQ requesters with timeout.
// Optional PRNG_ARB_STATS_EN adds saturating grant_count/timeout_count outputs.
module prng_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int OUTPUT_SIZE    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  prng_arbiter_if.slave       bus
`ifdef PRNG_ARB_STATS_EN
  ,
  output logic [15:0]         grant_count,
  output logic [7:0]          timeout_count
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t                 state;
  logic [IW-1:0]          ptr, gnt, pick;
  logic [OUTPUT_SIZE-1:0] pick_excl;
  logic [CW-1:0]          cnt;
  // Lowest set index at or above ptr wins; otherwise lowest index below ptr (wrap).
  always_comb begin
    pick = ptr;
    pick_excl = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req[i] && IW'(i) < ptr) begin
        pick = IW'(i);
        pick_excl = bus.req_exclude[i*OUTPUT_SIZE +: OUTPUT_SIZE];
      end
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req[i] && IW'(i) >= ptr) begin
        pick = IW'(i);
        pick_excl = bus.req_exclude[i*OUTPUT_SIZE +: OUTPUT_SIZE];
      end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= '0;
      gnt              <= '0;
      cnt              <= '0;
      bus.rsp_valid    <= '0;
      bus.rsp_data     <= '0;
      bus.rsp_error    <= 1'b0;
      bus.busy         <= 1'b0;
      bus.prng_next    <= 1'b0;
      bus.prng_exclude <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          gnt              <= pick;
          bus.prng_exclude <= pick_excl;
          bus.prng_next    <= 1'b1;
          bus.busy         <= 1'b1;
          state            <= ISSUE;
        end
        ISSUE: begin
          bus.prng_next <= 1'b0;
          cnt           <= '0;
          state         <= WAIT;
        end
        WAIT: if (bus.prng_valid || cnt == LAST) begin
          bus.rsp_data  <= bus.prng_valid ? bus.prng_data : '0;
          bus.rsp_error <= !bus.prng_valid;
          bus.rsp_valid <= NUM_REQ'(1) << gnt;
          state         <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: begin
          bus.rsp_valid <= '0;
          bus.rsp_data  <= '0;
          bus.rsp_error <= 1'b0;
          bus.busy      <= 1'b0;
          ptr           <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PRNG_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_count   <= '0;
      timeout_count <= '0;
    end else if (state == RESP) begin
      if (!bus.rsp_error && grant_count != '1) grant_count <= grant_count + 1'b1;
      if (bus.rsp_error && timeout_count != '1) timeout_count <= timeout_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_prng_arbiter.sv
// tb_prng_arbiter: directed vector table plus hand sequences for timeout-late-valid and mid-transaction reset
module tb_prng_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  int   n_good = 0;
  int   n_tmo = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  prng_arbiter_if #(.NUM_REQ(4), .OUTPUT_SIZE(4)) bus();
`ifdef PRNG_ARB_STATS_EN
  logic [15:0] grant_count;
  logic [7:0]  timeout_count;
`endif
  prng_arbiter #(.NUM_REQ(4), .OUTPUT_SIZE(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef PRNG_ARB_STATS_EN
    ,
    .grant_count(grant_count),
    .timeout_count(timeout_count)
`endif
  );
  typedef struct {
    logic [3:0] req;
    int         delay;
    logic [3:0] data;
    int         g;
    logic [3:0] ex;
    logic       err;
    int         lat;
    logic [3:0] after;
  } vec_t;
  vec_t v[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_next(output bit seen);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.prng_next) seen = 1;
    end
    chk("prng_next_seen", 32'(seen), 1);
  endtask
  // delay <= 0 means the PRNG never answers
  task automatic txn(input int delay, input logic [3:0] data, output logic [3:0] ex,
                     output logic [3:0] rv, output logic [3:0] rd, output logic re, output int lat);
    bit seen;
    int t0;
    wait_next(seen);
    ex = bus.prng_exclude;
    t0 = cyc;
    if (delay > 0) begin
      repeat (delay) @(negedge clk);
      bus.prng_valid = 1'b1;
      bus.prng_data  = data;
      @(negedge clk);
      bus.prng_valid = 1'b0;
      bus.prng_data  = '0;
    end
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.rsp_valid != 0) seen = 1;
      else @(negedge clk);
    end
    chk("rsp_valid_seen", 32'(seen), 1);
    lat = cyc - t0;
    rv  = bus.rsp_valid;
    rd  = bus.rsp_data;
    re  = bus.rsp_error;
  endtask
  task automatic run_vec(input int i);
    logic [3:0] ex, rv, rd;
    logic       re;
    int         lat;
    bus.req = v[i].req;
    txn(v[i].delay, v[i].data, ex, rv, rd, re, lat);
    chk($sformatf("v%0d_exclude", i), 32'(ex), 32'(v[i].ex));
    chk($sformatf("v%0d_rsp_valid", i), 32'(rv), 32'(4'b0001 << v[i].g));
    chk($sformatf("v%0d_rsp_data", i), 32'(rd), 32'(v[i].data));
    chk($sformatf("v%0d_rsp_error", i), 32'(re), 32'(v[i].err));
    chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].lat));
    if (v[i].err) n_tmo++;
    else n_good++;
    bus.req = v[i].after;
    @(negedge clk);
    chk($sformatf("v%0d_idle_after", i), 32'({bus.rsp_valid, bus.busy}), 0);
  endtask
  initial begin
    logic [3:0] ex, rv, rd;
    logic       re;
    int         lat;
    bit         seen;
    bus.req = '0;
    bus.req_exclude = 16'h7C93;
    bus.prng_valid = 1'b0;
    bus.prng_data = '0;
    v[0]  = '{4'b1111, 1, 4'h1, 0, 4'h3, 1'b0, 2, 4'b1110};
    v[1]  = '{4'b1110, 2, 4'h2, 1, 4'h9, 1'b0, 3, 4'b1100};
    v[2]  = '{4'b1100, 3, 4'hF, 2, 4'hC, 1'b0, 4, 4'b1000};
    v[3]  = '{4'b1000, 1, 4'h0, 3, 4'h7, 1'b0, 2, 4'b0101};
    v[4]  = '{4'b0101, 2, 4'h6, 0, 4'h3, 1'b0, 3, 4'b0101};
    v[5]  = '{4'b0101, 1, 4'h7, 2, 4'hC, 1'b0, 2, 4'b0101};
    v[6]  = '{4'b0101, 1, 4'h8, 0, 4'h3, 1'b0, 2, 4'b0101};
    v[7]  = '{4'b0101, 2, 4'h9, 2, 4'hC, 1'b0, 3, 4'b0001};
    v[8]  = '{4'b0001, 2, 4'hA, 0, 4'h3, 1'b0, 3, 4'b0000};
    v[9]  = '{4'b0010, 0, 4'h0, 1, 4'h9, 1'b1, 9, 4'b0000};
    v[10] = '{4'b1001, 1, 4'hB, 3, 4'h7, 1'b0, 2, 4'b1001};
    v[11] = '{4'b1001, 1, 4'hC, 0, 4'h3, 1'b0, 2, 4'b0000};
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.busy,
                              bus.prng_next, bus.prng_exclude}), 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) run_vec(i);
    // a PRNG strobe arriving after the timeout must not produce a response
    bus.prng_valid = 1'b1;
    bus.prng_data  = 4'hF;
    @(negedge clk);
    bus.prng_valid = 1'b0;
    bus.prng_data  = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_valid_ignored", 32'({bus.rsp_valid, bus.busy, bus.prng_next}), 0);
    end
    for (int i = 10; i < 12; i++) run_vec(i);
`ifdef PRNG_ARB_STATS_EN
    chk("grant_count", 32'(grant_count), 32'(n_good));
    chk("timeout_count", 32'(timeout_count), 32'(n_tmo));
`endif
    bus.req = 4'b0100;
    wait_next(seen);
    chk("rst_seq_exclude", 32'(bus.prng_exclude), 32'h0000000C);
    @(negedge clk);
    reset   = 1'b1;
    bus.req = 4'b1111;
    @(negedge clk);
    chk("mid_reset_outputs", 32'({bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.busy,
                                  bus.prng_next, bus.prng_exclude}), 0);
    reset = 1'b0;
    txn(1, 4'h5, ex, rv, rd, re, lat);
    chk("post_reset_grant", 32'(rv), 32'h1);
    chk("post_reset_data", 32'(rd), 32'h5);
    chk("post_reset_exclude", 32'(ex), 32'h3);
    bus.req = '0;
    @(negedge clk);
`ifdef PRNG_ARB_STATS_EN
    chk("grant_count_after_reset", 32'(grant_count), 1);
    chk("timeout_count_after_reset", 32'(timeout_count), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/prng_arbiter.md
Name: prng_arbiter

Overview:
Round-robin arbiter that shares one PRNG instance (next/exclude/valid/randomNumber handshake) among NUM_REQ requesters.
- Serialises requests and forwards the winner's exclude value to the PRNG.
- Returns the generated number to the granted requester only.
- Bounds every generation with a timeout so a hung or perpetually-clashing PRNG cannot deadlock the requesters.
- Sits between game/logic clients and the PRNG in the Logic hierarchy.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
OUTPUT_SIZE, 4, width of random number and exclude value
TIMEOUT_CYCLES, 64, max cycles in WAIT before abort (>=2)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request level
req_exclude  input  NUM_REQ*OUTPUT_SIZE  flattened exclude values; requester i uses bits [i*OUTPUT_SIZE +: OUTPUT_SIZE]
rsp_valid  output  NUM_REQ  one-hot, one-cycle response strobe
rsp_data  output  OUTPUT_SIZE  random number, valid with rsp_valid
rsp_error  output  1  qualifies rsp_valid: 1 = timeout, rsp_data = 0
busy  output  1  high in any state other than IDLE
prng_next  output  1  one-cycle generate pulse to PRNG
prng_exclude  output  OUTPUT_SIZE  exclude value to PRNG, held from ISSUE through RESP
prng_valid  input  1  PRNG result strobe
prng_data  input  OUTPUT_SIZE  PRNG result

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, rr pointer = 0, timeout counter = 0.
  - All outputs 0: rsp_valid, rsp_data, rsp_error, busy, prng_next, prng_exclude.
  - Reset asserted mid-transaction aborts it; no rsp_valid is issued for the aborted request.
- States:
  - IDLE: if |req, select the first set bit scanning from pointer upward with wrap (i = ptr, ptr+1, ..., NUM_REQ-1, 0, ...). Latch the grant index and its exclude slice, then go to ISSUE. If no req, stay in IDLE.
  - ISSUE: prng_next = 1 for exactly this cycle; prng_exclude = latched value; counter cleared; go to WAIT.
  - WAIT: if prng_valid, capture prng_data, rsp_error = 0, go to RESP. Else if counter == TIMEOUT_CYCLES-1, set rsp_data = 0, rsp_error = 1, go to RESP. Else counter++.
  - RESP: rsp_valid[grant] = 1 for one cycle, all other bits 0. Update pointer to (grant+1) mod NUM_REQ. Go to IDLE.
- Latency: req sampled in IDLE at cycle T; prng_next at T+1; prng_valid sampled at cycle W >= T+2; rsp_valid at W+1. Minimum request-to-response is 3 cycles.
- Handshake:
  - req[i] is a level, held until rsp_valid[i] is seen.
  - A requester may deassert req[i] at the edge where it samples rsp_valid[i].
  - If req[i] is still high in the following IDLE cycle, it is treated as a new request.
  - req changes and exclude changes are ignored outside IDLE; the exclude value is latched at grant.
- prng_valid outside WAIT is ignored; a late valid after a timeout is discarded.
- Simultaneous requests are resolved strictly by round-robin. A single requester holding req continuously is granted every transaction, since the pointer wraps back to it.
- A request arriving during RESP is first considered in the next IDLE cycle.
- Pointer arithmetic is modulo NUM_REQ; NUM_REQ need not be a power of two.
- The timeout counter is $clog2(TIMEOUT_CYCLES) bits wide and is compared exactly, never wrapping past the limit.

Optional Feature:
PRNG_ARB_STATS_EN
- Defined:
  - Adds output grant_count [15:0], incremented on every RESP with rsp_error = 0.
  - Adds output timeout_count [7:0], incremented on every RESP with rsp_error = 1.
  - Both counters saturate at all-ones and are cleared by reset.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single request (NUM_REQ=4, OUTPUT_SIZE=4):
  - Stimulus: req=0001, exclude0=4'h3, PRNG model returns 4'hA two cycles after prng_next.
  - Required: prng_exclude=3, rsp_valid=0001, rsp_data=A, rsp_error=0; rsp_valid exactly 3 cycles after prng_next (4 cycles after req sampled in IDLE).
- Simultaneous requests:
  - Stimulus: req=1111 held; each requester drops req on its response.
  - Required: grant order 0,1,2,3; each rsp_valid one-hot, never two bits high.
- Fairness:
  - Stimulus: req=0101 held continuously.
  - Required: grants alternate 0,2,0,2; pointer wrap verified.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, PRNG never asserts valid.
  - Required: rsp_valid for the requester with rsp_error=1, rsp_data=0, 8 WAIT cycles after ISSUE; a later prng_valid is ignored, state returns to IDLE.
- Reset mid-operation:
  - Stimulus: assert reset during WAIT.
  - Required: next cycle state is IDLE and all outputs are 0; no rsp_valid is issued; the pointer is back at 0, so the next simultaneous request grants requester 0.
- Optional feature (PRNG_ARB_STATS_EN):
  - Stimulus: 3 good responses followed by 1 timeout.
  - Required: grant_count=3, timeout_count=1.
